priority_decoder_seq: RTL
=========================

# priority_decoder_seq

Sequential inverse of the 32-bit priority encoder. It takes a leading-one position code (0..31) and the fraction bits that follow the leading one, and rebuilds the 32-bit fixed-point word with its leading one at that bit position. It sits on the float-to-fixed side of the exponential datapath. It uses a 5-stage iterative logarithmic shifter, one stage per clock, behind valid/ready handshakes on both sides.

## Interface
- No parameters. Width is fixed at 32 data bits and an 8-bit position code.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low; one clock, synchronous reset, active-low
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- pos  in  8  leading-one position code, same encoding as the encoder output (0..31 legal)
- mant  in  31  bits below the leading one, MSB-aligned (mant[30] is the bit just below the leading one)
- zero_in  in  1  value is zero; the position code is ignored
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- d_out  out  32  reconstructed word
- err  out  1  pos[7:5] was nonzero
- sticky  out  1  OR of all nonzero bits shifted out below bit 0

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: 5 cycles, counter cnt 0..4.
  - DONE: out_valid=1.
- IDLE → SHIFT on in_valid & in_ready. At that edge:
  - Load work register W = {1'b1, mant}.
  - Load shift amount s = 31 − pos[4:0] (5-bit unsigned).
  - Latch err_r = |pos[7:5] and zero_r = zero_in.
  - Clear sticky_r.
- SHIFT, cycle k (k = 0..4): if s[4−k]=1, W ← W >> 2^(4−k) and sticky_r ← sticky_r | (OR of the bits shifted out). After k=4 the state goes to DONE.
- DONE:
  - d_out = (err_r | zero_r) ? 0 : W.
  - err = err_r.
  - sticky = sticky_r & ~err_r & ~zero_r.
  - All outputs are held stable while out_ready=0.
  - DONE → IDLE on out_ready.
- err and zero requests still take the full 5 SHIFT cycles, so latency is uniform.
- Outside DONE, d_out, err and sticky are 0.
- Reset (rst_n=0 at a clock edge), from any state including mid-SHIFT or DONE:
  - State → IDLE; W, s, cnt, err_r, zero_r, sticky_r → 0.
  - The in-flight request is dropped.
- in_valid in a non-IDLE state is ignored, because in_ready=0.
- pos and mant are sampled only on the acceptance edge; later changes have no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, d_out=0, err=0, sticky=0.
- in_ready = (state==IDLE) and out_valid = (state==DONE). Both are decoded directly from the state register.
- Acceptance at edge T: out_valid is high from edge T+5 onward.
- Output handshake completes at the first edge with out_valid & out_ready. in_ready is high from that edge onward.
- Next acceptance is possible one edge after the output handshake. Peak throughput is one request per 7 cycles.
- Combinational paths:
  - None from in_valid to in_ready.
  - None from out_ready to out_valid.
  - Input-to-output latency is registered only.

## Configuration
- STICKY_EN defined: the sticky logic is compiled in as described above.
- STICKY_EN undefined:
  - sticky_r and its OR-reduction logic are removed.
  - The sticky port is tied to 0.
  - d_out, err, handshake and latency are identical.

## Test plan
- pos=31, mant=0, zero_in=0 → d_out=32'h8000_0000, err=0, sticky=0. out_valid rises exactly 5 edges after acceptance.
- pos=4, mant=31'h6000_0000 → d_out=32'h0000_001C, sticky=0. Then pos=0, mant=31'h0000_0001 → d_out=32'h0000_0001, sticky=1 (sticky=0 with STICKY_EN undefined).
- zero_in=1, pos=17 → d_out=0, err=0, sticky=0. Then pos=8'd40 → err=1, d_out=0, same 5-cycle latency.
- out_ready held low for 3 cycles in DONE → d_out, err and sticky stay stable and in_ready stays 0. in_valid pulses during SHIFT/DONE are ignored. After the handshake edge, in_ready=1.
- rst_n=0 for one edge during SHIFT cnt=2 → next cycle: state IDLE, in_ready=1, out_valid=0, d_out=0. A new request pos=12, mant=0 → d_out=32'h0000_1000 with no stale data.
- Round trip: 1000 random nonzero 32-bit words through the existing priority encoder, with the bits below the leading one as mant → d_out equals the original word, and sticky=0.

Source files
------------

// File: rtl/priority_decoder_seq_if.sv
// priority_decoder_seq_if
// Handshake and data bundle for the sequential priority decoder.
// The request side (in_*, pos, mant, zero_in) and the result side
// (out_*, d_out, err, sticky) share one interface. The slave modport
// is the decoder's view. The master modport is the view of whatever
// drives requests and consumes results.
interface priority_decoder_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  pos;
    logic [30:0] mant;
    logic        zero_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d_out;
    logic        err;
    logic        sticky;

    modport slave (
        input  in_valid, pos, mant, zero_in, out_ready,
        output in_ready, out_valid, d_out, err, sticky
    );

    modport master (
        output in_valid, pos, mant, zero_in, out_ready,
        input  in_ready, out_valid, d_out, err, sticky
    );
endinterface

// File: rtl/priority_decoder_seq.sv
// priority_decoder_seq
// Sequential inverse of the 32-bit priority encoder. It takes a
// leading-one position (0..31) and the fraction bits below the leading
// one. It rebuilds the 32-bit word by right-shifting {1, mant} by
// 31-pos, using a 5-stage logarithmic shifter that runs one stage per
// clock (16, 8, 4, 2, 1).
//
// Optional feature macro: STICKY_EN
//   defined   : sticky reports whether any nonzero bit fell off below bit 0
//   undefined : the sticky logic is absent and the sticky output is tied to 0
//
// Reset is synchronous and active low. Every request takes exactly 5
// shift cycles, including zero and error requests, so latency is uniform.
module priority_decoder_seq (
    input  logic clk,
    input  logic rst_n,
    priority_decoder_seq_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_work;
    logic [4:0]  r_shamt;
    logic [2:0]  r_cnt;
    logic        r_err;
    logic        r_zero;
    logic        r_sticky;

    logic        w_stageSel;
    logic [31:0] w_shifted;
    logic [31:0] w_nextWork;
    logic        w_idle;
    logic        w_done;
    logic        w_accept;
    logic        w_squash;

    // Select the shift distance and the shift-amount bit for the stage given by cnt (MSB stage first).
    always_comb begin
        w_stageSel = 1'b0;
        w_shifted  = r_work;
        case (r_cnt)
            3'd0: begin
                w_stageSel = r_shamt[4];
                w_shifted  = {16'b0, r_work[31:16]};
            end
            3'd1: begin
                w_stageSel = r_shamt[3];
                w_shifted  = {8'b0, r_work[31:8]};
            end
            3'd2: begin
                w_stageSel = r_shamt[2];
                w_shifted  = {4'b0, r_work[31:4]};
            end
            3'd3: begin
                w_stageSel = r_shamt[1];
                w_shifted  = {2'b0, r_work[31:2]};
            end
            3'd4: begin
                w_stageSel = r_shamt[0];
                w_shifted  = {1'b0, r_work[31:1]};
            end
            default: begin
                w_stageSel = 1'b0;
                w_shifted  = r_work;
            end
        endcase
        w_nextWork = w_stageSel ? w_shifted : r_work;
    end

    assign w_idle   = (r_state == ST_IDLE);
    assign w_done   = (r_state == ST_DONE);
    assign w_accept = w_idle & bus.in_valid;
    assign w_squash = r_err | r_zero;

    // Control FSM and datapath registers: accept, step the shifter 5 times, then hold the result until it is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_work  <= 32'd0;
            r_shamt <= 5'd0;
            r_cnt   <= 3'd0;
            r_err   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SHIFT;
                        r_work  <= {1'b1, bus.mant};
                        r_shamt <= 5'd31 - bus.pos[4:0];
                        r_cnt   <= 3'd0;
                        r_err   <= |bus.pos[7:5];
                        r_zero  <= bus.zero_in;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_nextWork;
                    if (r_cnt == 3'd4) begin
                        r_state <= ST_DONE;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef STICKY_EN
    logic [31:0] w_lostMask;
    logic        w_lostBits;

    // Mask of the bits that fall off the bottom in the current stage, if that stage shifts.
    always_comb begin
        w_lostMask = 32'd0;
        case (r_cnt)
            3'd0:    w_lostMask = 32'h0000_FFFF;
            3'd1:    w_lostMask = 32'h0000_00FF;
            3'd2:    w_lostMask = 32'h0000_000F;
            3'd3:    w_lostMask = 32'h0000_0003;
            3'd4:    w_lostMask = 32'h0000_0001;
            default: w_lostMask = 32'd0;
        endcase
        w_lostBits = w_stageSel & (|(r_work & w_lostMask));
    end

    // Accumulate the sticky bit across the shift stages. It is cleared on each new acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            r_sticky <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_sticky <= r_sticky | w_lostBits;
        end
    end
`else
    assign r_sticky = 1'b0;
`endif

    assign bus.in_ready  = w_idle;
    assign bus.out_valid = w_done;
    assign bus.d_out     = (w_done && !w_squash) ? r_work : 32'd0;
    assign bus.err       = w_done & r_err;
    assign bus.sticky    = w_done & r_sticky & ~w_squash;

endmodule
